// File: rtl/hi_iq_correlator.sv
// Falling-edge I/Q (or amplitude) correlator over 2^WIN_LOG2 ADC samples; each
// completed window is shifted out MSB-first on a slow SSP link during the next one.
module hi_iq_correlator #(
  parameter int ADC_W    = 8,
  parameter int WIN_LOG2 = 6,
  parameter int OUT_W    = 8,
  parameter int SHIFT    = 4
) (
  input  logic             ck_1356meg,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] adc_d,
  input  logic             en,
  input  logic [2:0]       sc_log2,
  input  logic [1:0]       mode,
  output logic             ssp_clk,
  output logic             ssp_frame,
  output logic             ssp_din,
  output logic             win_done
);
  localparam int ACC_W = ADC_W + WIN_LOG2 + 1;
  localparam int SR_W  = 2 * OUT_W;
  localparam int AMP_W = (ACC_W + 1 > SR_W) ? ACC_W + 1 : SR_W;
  localparam logic [2:0] K_MAX = 3'(WIN_LOG2 - 1);
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;
  localparam logic [AMP_W-1:0] AMP_MAX = AMP_W'({SR_W{1'b1}});

  typedef logic [WIN_LOG2-1:0] cnt_t;

  cnt_t                    cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [SR_W-1:0]         sr_q, sr_d;
  logic [2:0]              k_q, k_d, k_in;
  logic                    primed_q, primed_d, idle_q, idle_d;
  logic                    clk_q, clk_d, frame_q, frame_d, done_q, done_d;
  logic signed [ACC_W-1:0] adc_s;
  logic                    ref_i, ref_q;
  logic [ACC_W-1:0]        mag_i, mag_q, mag_hi, mag_lo;
  logic [AMP_W-1:0]        amp, amp_sh;
  logic [SR_W-1:0]         load_val;

  function automatic logic [OUT_W-1:0] sat_s(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT;
    if (s > S_MAX) return S_MAX[OUT_W-1:0];
    if (s < S_MIN) return S_MIN[OUT_W-1:0];
    return s[OUT_W-1:0];
  endfunction

  assign adc_s = signed'({{(ACC_W - ADC_W){1'b0}}, adc_d});
  assign ref_i = ~cnt_q[k_q];
  assign ref_q = ~(cnt_q[k_q] ^ cnt_q[k_q - 3'd1]);

  always_comb begin
    k_in = sc_log2;
    if (sc_log2 < 3'd2)       k_in = 3'd2;
    else if (sc_log2 > K_MAX) k_in = K_MAX;
  end

  // Result formatting; the mode seen at the window boundary selects the format.
  always_comb begin
    mag_i = acc_i_q[ACC_W-1] ? $unsigned(-acc_i_q) : $unsigned(acc_i_q);
    mag_q = acc_q_q[ACC_W-1] ? $unsigned(-acc_q_q) : $unsigned(acc_q_q);
    if (mag_i >= mag_q) begin
      mag_hi = mag_i;
      mag_lo = mag_q;
    end else begin
      mag_hi = mag_q;
      mag_lo = mag_i;
    end
    amp    = AMP_W'(mag_hi) + AMP_W'(mag_lo >> 1);
    amp_sh = amp >> SHIFT;
    if (mode[0]) load_val = (amp_sh > AMP_MAX) ? {SR_W{1'b1}} : amp_sh[SR_W-1:0];
    else         load_val = {sat_s(acc_i_q), sat_s(acc_q_q)};
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_i_d  = acc_i_q;
    acc_q_d  = acc_q_q;
    sr_d     = sr_q;
    k_d      = k_q;
    idle_d   = idle_q;
    primed_d = primed_q;
    clk_d    = clk_q;
    frame_d  = frame_q;
    done_d   = 1'b0;
    if (!en) begin
      cnt_d    = '0;
      acc_i_d  = '0;
      acc_q_d  = '0;
      sr_d     = '0;
      k_d      = '0;
      idle_d   = 1'b0;
      primed_d = 1'b0;
      clk_d    = 1'b0;
      frame_d  = 1'b0;
    end else begin
      cnt_d = cnt_q + cnt_t'(1);
      if (cnt_q[1:0] == 2'd0)      clk_d = 1'b1;
      else if (cnt_q[1:0] == 2'd2) clk_d = 1'b0;
      if (cnt_q == '0) begin
        k_d      = k_in;
        idle_d   = mode[1];
        primed_d = 1'b1;
        acc_i_d  = adc_s;
        acc_q_d  = adc_s;
        if (primed_q && !mode[1]) begin
          sr_d   = load_val;
          done_d = 1'b1;
        end else begin
          sr_d = '0;
        end
      end else begin
        acc_i_d = ref_i ? acc_i_q + adc_s : acc_i_q - adc_s;
        acc_q_d = ref_q ? acc_q_q + adc_s : acc_q_q - adc_s;
        if (cnt_q[1:0] == 2'd0) sr_d = {sr_q[SR_W-2:0], 1'b0};
      end
      // done_q marks the cycle right after a load, so only loaded windows frame.
      if (cnt_q == cnt_t'(1) && done_q) frame_d = 1'b1;
      else if (cnt_q == cnt_t'(3))      frame_d = 1'b0;
    end
  end

  always_ff @(negedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      sr_q     <= '0;
      k_q      <= '0;
      idle_q   <= 1'b0;
      primed_q <= 1'b0;
      clk_q    <= 1'b0;
      frame_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_i_q  <= acc_i_d;
      acc_q_q  <= acc_q_d;
      sr_q     <= sr_d;
      k_q      <= k_d;
      idle_q   <= idle_d;
      primed_q <= primed_d;
      clk_q    <= clk_d;
      frame_q  <= frame_d;
      done_q   <= done_d;
    end
  end

  assign ssp_clk   = clk_q & en;
  assign ssp_frame = frame_q & en & ~idle_q;
  assign ssp_din   = sr_q[SR_W-1] & en;
  assign win_done  = done_q & en;
endmodule
